// File: rtl/trace_capture_pkg.sv
// trace_capture_pkg: shared types and constants for the trace capture buffer.
// Used by trace_capture (macro TRACE_CAPTURE_STALL_EN) and its RAM.
package trace_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } cap_state_t;

    localparam int TIME_W_DEF  = 64;
    localparam int PROBE_W_DEF = 176;
    localparam int MISS_CNT_W  = 16;

    typedef struct packed {
        logic [TIME_W_DEF-1:0]  tstamp;
        logic [PROBE_W_DEF-1:0] probe;
    } trace_entry_t;

    function automatic logic [MISS_CNT_W-1:0] sat_inc(
        input logic [MISS_CNT_W-1:0] v
    );
        return (&v) ? v : v + MISS_CNT_W'(1);
    endfunction

endpackage

// File: rtl/trace_capture_ram.sv
// trace_capture_ram: one write port, one registered read port.
// The read register has a synchronous clear so the output starts at zero.
module trace_capture_ram
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int W     = 240,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_capture.sv
// trace_capture: pre/post-trigger circular trace buffer drained over valid/ready.
// Define TRACE_CAPTURE_STALL_EN to add dt_req_cap, which freezes time during DRAIN.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int PROBE_W = PROBE_W_DEF,
    parameter int TIME_W  = TIME_W_DEF,
    parameter int DT_W    = 32
) (
    input  logic                       emu_clk,
    input  logic                       emu_rst,
    input  logic                       emu_dec_cmp,
    input  logic [PROBE_W-1:0]         probe_data,
    input  logic [TIME_W-1:0]          emu_time,
    input  logic                       arm,
    input  logic                       trig,
    input  logic [$clog2(DEPTH)-1:0]   pre_trig,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [TIME_W+PROBE_W-1:0]  rd_data,
    output logic                       rd_last,
    output logic [1:0]                 cap_state,
    output logic [MISS_CNT_W-1:0]      miss_cnt
`ifdef TRACE_CAPTURE_STALL_EN
    ,
    output logic [DT_W-1:0]            dt_req_cap
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = TIME_W + PROBE_W;
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    cap_state_t            r_state;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_fill;
    logic [AW:0]           r_post_left;
    logic [AW:0]           r_rd_cnt;
    logic                  r_rd_valid;
    logic                  r_rd_last;
    logic [MISS_CNT_W-1:0] r_miss;

    logic          w_we;
    logic          w_re;
    logic          w_hs;
    logic          w_trig;
    logic          w_stb_miss;
    logic [AW-1:0] w_start;
    logic [AW:0]   w_post_init;
    logic [EW-1:0] w_wdata;

    assign w_we    = emu_dec_cmp && (r_state == ARMED || r_state == POST);
    assign w_hs    = r_rd_valid && rd_ready;
    assign w_re    = (r_state == DRAIN) && (r_rd_cnt != '0)
                  && (!r_rd_valid || rd_ready);
    assign w_trig  = (r_state == ARMED) && trig
                  && (r_fill >= {1'b0, pre_trig});
    assign w_start = r_wr_ptr - pre_trig;
    assign w_wdata = {emu_time, probe_data};

    // A strobe in the trigger cycle is already the first post sample.
    assign w_post_init = DEPTH_C - {1'b0, pre_trig}
                       - {{AW{1'b0}}, emu_dec_cmp};

`ifdef TRACE_CAPTURE_STALL_EN
    assign w_stb_miss = 1'b0;
    assign dt_req_cap = (r_state == DRAIN) ? {DT_W{1'b0}} : {DT_W{1'b1}};
`else
    logic [DT_W-1:0] w_dt_unused;
    assign w_dt_unused = {DT_W{1'b1}};
    assign w_stb_miss  = (r_state == DRAIN) && emu_dec_cmp;
`endif

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_post_left <= '0;
            r_rd_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_miss      <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + ONE_A;
            end
            if (w_stb_miss) begin
                r_miss <= sat_inc(r_miss);
            end
            unique case (r_state)
                IDLE: begin
                    if (arm) begin
                        r_state  <= ARMED;
                        r_wr_ptr <= '0;
                        r_fill   <= '0;
                        r_miss   <= '0;
                    end
                end
                ARMED: begin
                    if (emu_dec_cmp && r_fill != DEPTH_C) begin
                        r_fill <= r_fill + ONE_C;
                    end
                    if (w_trig) begin
                        r_rd_ptr    <= w_start;
                        r_rd_cnt    <= DEPTH_C;
                        r_post_left <= w_post_init;
                        r_state     <= (w_post_init == '0) ? DRAIN : POST;
                    end
                end
                POST: begin
                    if (emu_dec_cmp) begin
                        r_post_left <= r_post_left - ONE_C;
                        if (r_post_left == ONE_C) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_re) begin
                        r_rd_ptr   <= r_rd_ptr + ONE_A;
                        r_rd_cnt   <= r_rd_cnt - ONE_C;
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_rd_cnt == ONE_C);
                    end else if (w_hs) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                    end
                    if (w_hs && r_rd_last) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    trace_capture_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_ram (
        .i_clk   (emu_clk),
        .i_rst   (emu_rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data)
    );

    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign cap_state = r_state;
    assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: randomized scoreboard bench for trace_capture, DEPTH = 8.
// A sample-list model predicts drained entries; a monitor pops on each handshake.
`timescale 1ns/1ps
module tb_trace_capture;
    import trace_capture_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 176;
    localparam int TW    = 64;
    localparam int EW    = TW + PW;

    logic           clk = 1'b0;
    logic           emu_rst = 1'b1;
    logic           emu_dec_cmp = 1'b0;
    logic [PW-1:0]  probe_data = '0;
    logic [TW-1:0]  emu_time = '0;
    logic           arm = 1'b0;
    logic           trig = 1'b0;
    logic [2:0]     pre_trig = '0;
    logic           rd_valid;
    logic           rd_ready = 1'b0;
    logic [EW-1:0]  rd_data;
    logic           rd_last;
    logic [1:0]     cap_state;
    logic [15:0]    miss_cnt;
`ifdef TRACE_CAPTURE_STALL_EN
    logic [31:0]    dt_req_cap;
`endif

    always #5 clk = ~clk;

    trace_capture #(
        .DEPTH   (DEPTH),
        .PROBE_W (PW),
        .TIME_W  (TW),
        .DT_W    (32)
    ) dut (
        .emu_clk     (clk),
        .emu_rst     (emu_rst),
        .emu_dec_cmp (emu_dec_cmp),
        .probe_data  (probe_data),
        .emu_time    (emu_time),
        .arm         (arm),
        .trig        (trig),
        .pre_trig    (pre_trig),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .cap_state   (cap_state),
        .miss_cnt    (miss_cnt)
`ifdef TRACE_CAPTURE_STALL_EN
        ,
        .dt_req_cap  (dt_req_cap)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout expected completion", nm);
    endtask

    typedef struct packed {
        trace_entry_t e;
        logic         last;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: the list of stored samples since arm.
    cap_state_t   m_phase = IDLE;
    trace_entry_t m_s[$];
    int           m_ntrig = 0;
    int           m_pre = 0;
    int           m_post = 0;
    int           m_left = 0;
    logic [15:0]  m_miss = '0;
    int           m_bubble = 0;

    task automatic try_complete();
        exp_t x;
        if (m_post == DEPTH - m_pre) begin
            for (int i = 0; i < DEPTH; i++) begin
                x.e    = m_s[m_ntrig - m_pre + i];
                x.last = (i == DEPTH - 1);
                exp_q.push_back(x);
            end
            m_phase = DRAIN;
            m_left  = DEPTH;
        end
    endtask

    task automatic model_step();
        trace_entry_t te;
        te.tstamp = emu_time;
        te.probe  = probe_data;
        if (emu_rst) begin
            m_phase = IDLE;
            m_s.delete();
            m_miss = '0;
            return;
        end
        case (m_phase)
            IDLE: begin
                if (arm) begin
                    m_phase = ARMED;
                    m_s.delete();
                    m_miss = '0;
                end
            end
            ARMED: begin
                if (trig && m_s.size() >= int'(pre_trig)) begin
                    m_phase = POST;
                    m_ntrig = m_s.size();
                    m_pre   = int'(pre_trig);
                    m_post  = 0;
                end
                if (emu_dec_cmp) begin
                    m_s.push_back(te);
                    if (m_phase == POST) m_post++;
                end
                if (m_phase == POST) try_complete();
            end
            POST: begin
                if (emu_dec_cmp) begin
                    m_s.push_back(te);
                    m_post++;
                end
                try_complete();
            end
            DRAIN: begin
`ifndef TRACE_CAPTURE_STALL_EN
                if (emu_dec_cmp && m_miss != 16'hFFFF) m_miss++;
`endif
                if (rd_valid && rd_ready) begin
                    m_left--;
                    if (m_left == 0) m_phase = IDLE;
                end
            end
        endcase
    endtask

    task automatic check_cycle();
        chk("cap_state", cap_state, m_phase);
        chk("miss_cnt", miss_cnt, m_miss);
`ifdef TRACE_CAPTURE_STALL_EN
        chk("dt_req_cap", dt_req_cap,
            (m_phase == DRAIN) ? 32'h0 : 32'hFFFF_FFFF);
`endif
        if (m_phase != DRAIN) begin
            m_bubble = 0;
            chk("rd_valid_off", rd_valid, 1'b0);
        end else if (rd_valid) begin
            m_bubble = 0;
        end else begin
            m_bubble++;
            chk("rd_bubble_le2", m_bubble <= 2, 1'b1);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake.
    int          n_xfer = 0;
    bit          first_seen = 1'b0;
    logic [63:0] first_t = '0;
    logic [63:0] last_t = '0;
    bit          prev_stall = 1'b0;
    logic [EW-1:0] prev_data = '0;
    logic        prev_last = 1'b0;
    exp_t        mon_x;

    always @(negedge clk) begin
        if (emu_rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", rd_valid, 1'b1);
                chk("hold_data", rd_data, prev_data);
                chk("hold_last", rd_last, prev_last);
            end
            if (rd_valid && rd_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL extra_xfer: got %0h expected none",
                             rd_data);
                end else begin
                    mon_x = exp_q.pop_front();
                    chk("rd_data", rd_data, mon_x.e);
                    chk("rd_last", rd_last, mon_x.last);
                end
                if (!first_seen) begin
                    first_t    = rd_data[EW-1:PW];
                    first_seen = 1'b1;
                end
                if (rd_last) last_t = rd_data[EW-1:PW];
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
        end
    end

    int rdy_mode = 0;
    int rdy_k = 0;

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic cyc(input bit s, input bit t, input bit a);
        emu_dec_cmp = s;
        trig        = t;
        arm         = a;
        probe_data  = PW'({$urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom});
        case (rdy_mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (rdy_k % 4 == 0) || (rdy_k % 4 == 3);
            default: rd_ready = 1'($urandom_range(0, 1));
        endcase
        rdy_k++;
        tick();
        emu_time++;
    endtask

    task automatic do_reset();
        emu_rst = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        emu_rst = 1'b0;
    endtask

    task automatic fill_post();
        int k;
        k = 0;
        while (m_phase == POST && k < 100) begin
            cyc(1, 0, 0);
            k++;
        end
        if (m_phase != DRAIN) fail_to("post_fill");
    endtask

    task automatic drain(input int nstb, input bit arm_first);
        int k;
        k          = 0;
        n_xfer     = 0;
        first_seen = 1'b0;
        rdy_k      = 0;
        while (m_phase == DRAIN && k < 200) begin
            cyc(k < nstb, 1'($urandom_range(0, 1)), arm_first && k == 0);
            k++;
        end
        if (m_phase == DRAIN) fail_to("drain");
        chk("xfer_count", n_xfer, DEPTH);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic arm_capture(input logic [2:0] pre);
        pre_trig = pre;
        cyc(0, 0, 1);
        emu_time = '0;
    endtask

    initial begin
        do_reset();
        chk("rst_state", cap_state, 2'd0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_last", rd_last, 1'b0);
        chk("rst_data", rd_data, '0);
        chk("rst_miss", miss_cnt, 16'd0);
`ifdef TRACE_CAPTURE_STALL_EN
        chk("rst_dt", dt_req_cap, 32'hFFFF_FFFF);
`endif

        // Basic capture: pre 3, trigger at fill 5 -> times 2..9.
        rdy_mode = 0;
        arm_capture(3'd3);
        repeat (5) cyc(1, 0, 0);
        cyc(1, 1, 0);
        fill_post();
        drain(0, 0);
        chk("basic_first_t", first_t, 64'd2);
        chk("basic_last_t", last_t, 64'd9);

        // Early trigger ignored, later one taken.
        arm_capture(3'd3);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("early_trig_state", cap_state, 2'd1);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        fill_post();
        drain(0, 0);
        chk("early_first_t", first_t, 64'd0);

        // Back-pressure 1-0-0-1 through the drain.
        rdy_mode = 1;
        arm_capture(3'd4);
        repeat (6) cyc(1'($urandom_range(0, 1)), 0, 0);
        repeat (5) cyc(1, 0, 0);
        cyc(1'($urandom_range(0, 1)), 1, 0);
        fill_post();
        drain(0, 0);

        // Wrap-around with pre_trig 0.
        rdy_mode = 2;
        arm_capture(3'd0);
        repeat (20) cyc(1, 0, 0);
        cyc(1, 1, 0);
        fill_post();
        drain(0, 0);
        chk("wrap_first_t", first_t, 64'd20);
        chk("wrap_last_t", last_t, 64'd27);

        // Reset in POST, then a clean capture with arm during DRAIN.
        rdy_mode = 0;
        arm_capture(3'd2);
        repeat (4) cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        chk("pre_rst_state", cap_state, 2'd2);
        emu_rst = 1'b1;
        cyc(1, 0, 0);
        emu_rst = 1'b0;
        chk("mid_rst_state", cap_state, 2'd0);
        chk("mid_rst_valid", rd_valid, 1'b0);
        arm_capture(3'd2);
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 0);
        fill_post();
        drain(0, 1);
        chk("clean_first_t", first_t, 64'd1);

        // Strobes during DRAIN.
        rdy_mode = 1;
        arm_capture(3'd1);
        repeat (2) cyc(1, 0, 0);
        cyc(1, 1, 0);
        fill_post();
        drain(4, 0);
`ifdef TRACE_CAPTURE_STALL_EN
        chk("drain_miss", miss_cnt, 16'd0);
`else
        chk("drain_miss", miss_cnt, 16'd4);
`endif

        // Randomized captures.
        for (int r = 0; r < 6; r++) begin
            int k;
            rdy_mode = 2;
            arm_capture(3'($urandom_range(0, DEPTH - 1)));
            k = 0;
            while (m_phase == ARMED && k < 300) begin
                cyc(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, 0);
                k++;
            end
            if (m_phase == ARMED) fail_to("rand_trig");
            k = 0;
            while (m_phase == POST && k < 300) begin
                cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
                k++;
            end
            if (m_phase != DRAIN) fail_to("rand_post");
            drain($urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
